alu_issue_stage: RTL and testbench

- Decode-to-execute pipeline register for the pipelined RV32I core; it is the producing end of the ALU interface.
- Each cycle it can accept one decoded-stage bundle (instruction, PC, register-file read data) and decode it.
- It registers the 4-bit ALU operation code, the two 32-bit operands, and writeback control for the execute stage.
- Valid/ready handshake on both sides; supports stall and flush.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_op_decode.sv | 137 +++++++++++++
 rtl/alu_issue_stage.sv | 150 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : alu_pkg                                                      |
// | Description : Shared constants for the RV32I decode-to-execute boundary:   |
// |               datapath widths, ALU operation codes, base opcodes and the   |
// |               operand-source selects produced by the decoder.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  // ALU operation codes
  localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [OPW-1:0] ALU_AND  = 4'd2;
  localparam logic [OPW-1:0] ALU_OR   = 4'd3;
  localparam logic [OPW-1:0] ALU_XOR  = 4'd4;
  localparam logic [OPW-1:0] ALU_SLL  = 4'd5;
  localparam logic [OPW-1:0] ALU_SRL  = 4'd6;
  localparam logic [OPW-1:0] ALU_SRA  = 4'd7;
  localparam logic [OPW-1:0] ALU_SLT  = 4'd8;
  localparam logic [OPW-1:0] ALU_SLTU = 4'd9;

  // RV32I base opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Operand source selects
  typedef enum logic [1:0] {
    OP1_ZERO = 2'd0,
    OP1_RS1  = 2'd1,
    OP1_PC   = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_IMM   = 2'd0,
    OP2_RS2   = 2'd1,
    OP2_SHAMT = 2'd2
  } op2_sel_e;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_op_decode                                                |
// | Description : Purely combinational RV32I decoder. Maps a raw instruction   |
// |               to an ALU operation, operand-source selects, the immediate,  |
// |               the writeback enable and an illegal-encoding flag.           |
// | Ports       : i_instr     - raw 32-bit instruction                         |
// |               o_alu_op    - ALU operation code                             |
// |               o_op1_sel   - first operand source                           |
// |               o_op2_sel   - second operand source                          |
// |               o_imm       - decoded immediate (0 when unused)              |
// |               o_reg_write - writeback enable (never set for rd = x0)       |
// |               o_illegal   - unsupported encoding                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]     i_instr,
  output logic [OPW-1:0]  o_alu_op,
  output op1_sel_e        o_op1_sel,
  output op2_sel_e        o_op2_sel,
  output logic [XLEN-1:0] o_imm,
  output logic            o_reg_write,
  output logic            o_illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_sh;
  logic            w_r_legal;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_imm_i  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_imm_sh = {{(XLEN-5){1'b0}}, i_instr[24:20]};

  // funct7 = 0100000 is only meaningful for SUB and SRA
  assign w_r_legal = (w_f7 == 7'b0000000) ||
                     ((w_f7 == 7'b0100000) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)));

  always_comb begin
    o_alu_op    = ALU_ADD;
    o_op1_sel   = OP1_ZERO;
    o_op2_sel   = OP2_IMM;
    o_imm       = '0;
    o_reg_write = 1'b0;
    o_illegal   = 1'b0;

    case (w_opcode)
      OPC_OP: begin
        if (w_r_legal) begin
          o_op1_sel   = OP1_RS1;
          o_op2_sel   = OP2_RS2;
          o_reg_write = 1'b1;
          case (w_f3)
            3'd0: o_alu_op = w_f7[5] ? ALU_SUB : ALU_ADD;
            3'd1: begin o_alu_op = ALU_SLL; o_op2_sel = OP2_SHAMT; end
            3'd2: o_alu_op = ALU_SLT;
            3'd3: o_alu_op = ALU_SLTU;
            3'd4: o_alu_op = ALU_XOR;
            3'd5: begin
              o_alu_op  = w_f7[5] ? ALU_SRA : ALU_SRL;
              o_op2_sel = OP2_SHAMT;
            end
            3'd6: o_alu_op = ALU_OR;
            default: o_alu_op = ALU_AND;
          endcase
        end else begin
          o_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        o_op1_sel   = OP1_RS1;
        o_imm       = w_imm_i;
        o_reg_write = 1'b1;
        case (w_f3)
          3'd0: o_alu_op = ALU_ADD;
          3'd1: begin o_alu_op = ALU_SLL; o_imm = w_imm_sh; end
          3'd2: o_alu_op = ALU_SLT;
          3'd3: o_alu_op = ALU_SLTU;
          3'd4: o_alu_op = ALU_XOR;
          3'd5: begin
            o_alu_op = i_instr[30] ? ALU_SRA : ALU_SRL;
            o_imm    = w_imm_sh;
          end
          3'd6: o_alu_op = ALU_OR;
          default: o_alu_op = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        o_op1_sel   = OP1_RS1;
        o_imm       = w_imm_i;
        o_reg_write = 1'b1;
      end
      OPC_STORE: begin
        o_op1_sel = OP1_RS1;
        o_imm     = w_imm_s;
      end
      OPC_LUI: begin
        o_imm       = w_imm_u;
        o_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        o_op1_sel   = OP1_PC;
        o_imm       = w_imm_u;
        o_reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        o_op1_sel = OP1_RS1;
        o_op2_sel = OP2_RS2;
        // funct3[2] splits equality from ordered compares, funct3[1] picks unsigned
        if (!w_f3[2])     o_alu_op = ALU_SUB;
        else if (w_f3[1]) o_alu_op = ALU_SLTU;
        else              o_alu_op = ALU_SLT;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU computes the link value pc + 4; the target is formed elsewhere
        o_op1_sel   = OP1_PC;
        o_imm       = {{(XLEN-3){1'b0}}, 3'd4};
        o_reg_write = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase

    if (i_instr[11:7] == 5'd0) o_reg_write = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_stage                                              |
// | Description : Decode-to-execute pipeline register of the RV32I core.       |
// |               Decodes one bundle per cycle and registers ALU op, operands  |
// |               and writeback control behind a valid/ready handshake with    |
// |               stall and flush.                                             |
// | Option      : ALU_ISSUE_FWD_EN - when defined, EX/MEM forwarding replaces  |
// |               register-file data at load time; otherwise fwd_* ignored.    |
// | Ports       : clk, rst (async, active-high)                                |
// |               in_valid/in_ready, instr, pc, rs1_data, rs2_data - input     |
// |               flush - kill held bundle and any same-cycle load             |
// |               out_valid/out_ready, alu_op, operand_1, operand_2,           |
// |               store_data, rd, reg_write, illegal - execute bundle          |
// |               fwd_valid, fwd_rd, fwd_data - EX/MEM forwarding source       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int OPW  = alu_pkg::OPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] operand_1,
  output logic [XLEN-1:0] operand_2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data
);

  logic [OPW-1:0]  w_alu_op;
  op1_sel_e        w_op1_sel;
  op2_sel_e        w_op2_sel;
  logic [XLEN-1:0] w_imm;
  logic            w_reg_write;
  logic            w_illegal;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [4:0]      w_rd;
  logic            w_load;

  logic            r_valid;
  logic [OPW-1:0]  r_alu_op;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_store_data;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_illegal;

  alu_op_decode u_decode (
    .i_instr     (instr),
    .o_alu_op    (w_alu_op),
    .o_op1_sel   (w_op1_sel),
    .o_op2_sel   (w_op2_sel),
    .o_imm       (w_imm),
    .o_reg_write (w_reg_write),
    .o_illegal   (w_illegal)
  );

`ifdef ALU_ISSUE_FWD_EN
  assign w_rs1_val = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[19:15]))
                     ? fwd_data : rs1_data;
  assign w_rs2_val = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[24:20]))
                     ? fwd_data : rs2_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
  assign w_rs1_val    = rs1_data;
  assign w_rs2_val    = rs2_data;
`endif

  always_comb begin
    w_op1 = '0;
    case (w_op1_sel)
      OP1_RS1: w_op1 = w_rs1_val;
      OP1_PC:  w_op1 = pc;
      default: w_op1 = '0;
    endcase
  end

  // Shifts pass only shamt because the ALU shifts by the whole operand
  always_comb begin
    w_op2 = w_imm;
    case (w_op2_sel)
      OP2_RS2:   w_op2 = w_rs2_val;
      OP2_SHAMT: w_op2 = {{(XLEN-5){1'b0}}, w_rs2_val[4:0]};
      default:   w_op2 = w_imm;
    endcase
  end

  assign w_rd     = w_reg_write ? instr[11:7] : 5'd0;
  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_alu_op     <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_alu_op     <= w_alu_op;
      r_op1        <= w_op1;
      r_op2        <= w_op2;
      r_store_data <= w_rs2_val;
      r_rd         <= w_rd;
      r_reg_write  <= w_reg_write;
      r_illegal    <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign alu_op     = r_alu_op;
  assign operand_1  = r_op1;
  assign operand_2  = r_op2;
  assign store_data = r_store_data;
  assign rd         = r_rd;
  assign reg_write  = r_reg_write;
  assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_stage                                           |
// | Description : Scoreboard bench for alu_issue_stage. Expected bundles are   |
// |               computed by an independent decode model when a load is       |
// |               driven and compared while the DUT presents them.             |
// | Option      : ALU_ISSUE_FWD_EN selects the forwarding-aware model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  alu_op;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;
  logic        fwd_valid = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [31:0] fwd_data = '0;

  alu_issue_stage dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .instr (instr), .pc (pc), .rs1_data (rs1_data), .rs2_data (rs2_data),
    .flush (flush),
    .out_valid (out_valid), .out_ready (out_ready),
    .alu_op (alu_op), .operand_1 (operand_1), .operand_2 (operand_2),
    .store_data (store_data), .rd (rd), .reg_write (reg_write), .illegal (illegal),
    .fwd_valid (fwd_valid), .fwd_rd (fwd_rd), .fwd_data (fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  aop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic        st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_valid  = 1'b0;
  logic m_acc    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: op_of = alt ? 4'd1 : 4'd0;
      3'd1: op_of = 4'd5;
      3'd2: op_of = 4'd8;
      3'd3: op_of = 4'd9;
      3'd4: op_of = 4'd4;
      3'd5: op_of = alt ? 4'd7 : 4'd6;
      3'd6: op_of = 4'd3;
      default: op_of = 4'd2;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0]  f3;
    logic [31:0] sx_i;
    f3   = ins[14:12];
    sx_i = {{20{ins[31]}}, ins[31:20]};
    e    = '0;
    e.sd = b;
    case (ins[6:0])
      7'h33: begin
        if (ins[31:25] == 7'h00 || (ins[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          e.aop = op_of(f3, ins[30]);
          e.op1 = a;
          e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, b[4:0]} : b;
          e.rw  = 1'b1;
        end else e.ill = 1'b1;
      end
      7'h13: begin
        e.aop = op_of(f3, (f3 == 3'd5) && ins[30]);
        e.op1 = a;
        e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, ins[24:20]} : sx_i;
        e.rw  = 1'b1;
      end
      7'h03: begin e.op1 = a; e.op2 = sx_i; e.rw = 1'b1; end
      7'h23: begin
        e.op1 = a;
        e.op2 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        e.st  = 1'b1;
      end
      7'h37: begin e.op2 = {ins[31:12], 12'b0}; e.rw = 1'b1; end
      7'h17: begin e.op1 = p; e.op2 = {ins[31:12], 12'b0}; e.rw = 1'b1; end
      7'h63: begin
        e.op1 = a; e.op2 = b;
        e.aop = f3[2] ? (f3[1] ? 4'd9 : 4'd8) : 4'd1;
      end
      7'h6F, 7'h67: begin e.op1 = p; e.op2 = 32'd4; e.rw = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.rw && ins[11:7] != 5'd0) e.rd = ins[11:7];
    else begin e.rw = 1'b0; e.rd = 5'd0; end
    model = e;
  endfunction

  // Monitor/scoreboard: outputs sampled on the falling edge
  always @(negedge clk) begin
    logic  exp_rdy;
    logic [31:0] a, b;
    exp_t  e;
    if (rst) begin
      m_acc = 1'b0;
    end else begin
      exp_rdy = !m_valid || out_ready;
      check_eq("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      check_eq("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
        if (sb.size() == 0) check_eq("sb_empty", 32'd0, 32'd1);
        else begin
          e = sb[0];
          check_eq("alu_op", {28'b0, alu_op}, {28'b0, e.aop});
          check_eq("operand_1", operand_1, e.op1);
          check_eq("operand_2", operand_2, e.op2);
          check_eq("rd", {27'b0, rd}, {27'b0, e.rd});
          check_eq("reg_write", {31'b0, reg_write}, {31'b0, e.rw});
          check_eq("illegal", {31'b0, illegal}, {31'b0, e.ill});
          if (e.st) check_eq("store_data", store_data, e.sd);
        end
      end
      m_acc = in_valid && !flush && exp_rdy;
      if (flush) begin
        if (m_valid && sb.size() != 0) void'(sb.pop_front());
        m_valid = 1'b0;
      end else begin
        if (m_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
        if (m_acc) begin
          a = rs1_data;
          b = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
          if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[19:15]) a = fwd_data;
          if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[24:20]) b = fwd_data;
`endif
          sb.push_back(model(instr, pc, a, b));
          m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    int   n;
    logic ok;
    instr = ins; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!m_acc && n < 40);
    ok = m_acc;
    #1;
    in_valid = 1'b0;
    if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    enc_r = {f7, s2, s1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    enc_i = {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] s2,
                                        input logic [4:0] s1);
    enc_s = {imm[11:5], s2, s1, 3'd2, imm[4:0], 7'h23};
  endfunction

  initial begin
    int n;
    #2;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_alu_op", {28'b0, alu_op}, 32'd0);
    check_eq("rst_operand_1", operand_1, 32'd0);
    check_eq("rst_operand_2", operand_2, 32'd0);
    check_eq("rst_rd_rw_ill", {25'b0, rd, reg_write, illegal}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // Back-to-back traffic with the execute stage always ready
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7);          // add x3,x1,x2
    send(enc_i(12'h403, 5'd1, 3'd5, 5'd4, 7'h13), 32'h0, 32'h80000000, 32'd0); // srai x4,x1,3
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd6), 32'h0, 32'd1, 32'h25);         // sll
    send(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7), 32'h0, 32'd9, 32'd4);          // sub
    send(enc_i(12'hFFB, 5'd1, 3'd0, 5'd8, 7'h13), 32'h0, 32'd20, 32'd0);      // addi -5
    send(enc_i(12'h008, 5'd1, 3'd2, 5'd9, 7'h03), 32'h0, 32'h1000, 32'd0);    // lw
    send(enc_s(12'hFFC, 5'd2, 5'd1), 32'h0, 32'h2000, 32'hDEADBEEF);          // sw
    send({20'h12345, 5'd5, 7'h37}, 32'h0, 32'd11, 32'd12);                    // lui
    send({20'h00001, 5'd10, 7'h17}, 32'h100, 32'd11, 32'd12);                 // auipc
    send({7'h0, 5'd2, 5'd1, 3'd6, 5'd0, 7'h63}, 32'h0, 32'd3, 32'd4);          // bltu
    send({7'h0, 5'd2, 5'd1, 3'd0, 5'd8, 7'h63}, 32'h0, 32'd3, 32'd4);          // beq
    send({20'h00010, 5'd1, 7'h6F}, 32'h200, 32'd0, 32'd0);                    // jal
    send(enc_i(12'h010, 5'd2, 3'd0, 5'd1, 7'h67), 32'h300, 32'd6, 32'd0);     // jalr
    send(32'h0000007F, 32'h0, 32'd1, 32'd2);                                  // illegal opcode
    send(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'd1, 32'd2);          // reserved funct7
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'h0, 32'd1, 32'd2);          // add x0
    send(enc_i(12'h7FF, 5'd1, 3'd3, 5'd12, 7'h13), 32'h0, 32'd1, 32'd2);      // sltiu
    idle(2);

    // Stall: B waits three cycles behind a held A
    out_ready = 1'b0;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd13), 32'h0, 32'hF0F0, 32'h0FF0);
    fork
      send(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd14), 32'h0, 32'hFF00, 32'h0F0F);
      begin
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(3);

    // Flush with a same-cycle load into an empty stage
    out_ready = 1'b0;
    instr = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd15);
    in_valid = 1'b1;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    idle(1);
    // Flush of a held bundle
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd16), 32'h0, 32'd1, 32'd2);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(2);

    // Asynchronous reset in the middle of a stall
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd17), 32'h0, 32'd1, 32'd2);
    idle(1);
    #2;
    rst = 1'b1;
    sb.delete();
    m_valid = 1'b0;
    m_acc = 1'b0;
    #1;
    check_eq("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("arst_alu_op", {28'b0, alu_op}, 32'd0);
    check_eq("arst_operands", operand_1 | operand_2 | store_data, 32'd0);
    check_eq("arst_rd_rw_ill", {25'b0, rd, reg_write, illegal}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(1);

    // Forwarding source active; ignored when the option is absent
    fwd_valid = 1'b1;
    fwd_rd = 5'd1;
    fwd_data = 32'hAA;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7);
    send(enc_s(12'h004, 5'd1, 5'd2), 32'h0, 32'd8, 32'd9);
    fwd_rd = 5'd0;
    send(enc_r(7'h00, 5'd2, 5'd0, 3'd0, 5'd3), 32'h0, 32'd9, 32'd7);
    fwd_valid = 1'b0;

    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0 || m_valid) check_eq("drain_timeout", 32'd0, 32'd1);
    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
